// File: rtl/ps2_sequence_translator_if.sv
// ps2_sequence_translator_if: scancode input strobe and UART FIFO write port
interface ps2_sequence_translator_if;
    logic       scancodeDone;
    logic [7:0] scancode;
    logic       fifoFull;
    logic       fifoWriteRequest;
    logic [7:0] fifoInData;
    modport master(output scancodeDone, scancode, fifoFull, input fifoWriteRequest, fifoInData);
    modport slave(input scancodeDone, scancode, fifoFull, output fifoWriteRequest, fifoInData);
endinterface

// File: rtl/ps2_sequence_translator.sv
// ps2_sequence_translator: PS/2 set-2 scancodes to terminal byte stream with
// modifier tracking, ANSI escape sequences and a backpressured byte queue.
module ps2_sequence_translator #(
    parameter int         QUEUE_DEPTH    = 16,
    parameter bit         ALT_ESC_PREFIX = 1'b1,
    parameter logic [7:0] BS_CODE        = 8'h7F,
    parameter int         DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_sequence_translator_if.slave bus,
    output logic                  capsLock,
    output logic [5:0]            modifiers,
    output logic [DROP_CNT_W-1:0] droppedCount
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    typedef enum logic [2:0] {IDLE, E0, BREAK, E0_BREAK, SKIP} state_t;
    state_t      state;
    logic [2:0]  skip;
    logic        caps_held;
    logic [7:0]  mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, free;
    logic        ev_e0, make_ev, rel_ev, shift, ctrl, alt, prefix, push, drop, pop;
    logic [5:0]  mask;
    logic [7:0]  ch, sh, key;
    logic [31:0] base;
    logic [39:0] seq;
    logic [2:0]  blen, len;
    always_comb begin
        shift = modifiers[1] | modifiers[0];
        ctrl = modifiers[3] | modifiers[2];
        alt = modifiers[5] | modifiers[4];
        ev_e0 = state == E0 || state == E0_BREAK;
        make_ev = bus.scancodeDone && ((state == IDLE && !(bus.scancode inside {8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC}))
                  || (state == E0 && !(bus.scancode inside {8'hF0, 8'h12})));
        rel_ev = bus.scancodeDone && (state == BREAK || state == E0_BREAK);
        mask = 6'b0;
        case ({ev_e0, bus.scancode})
            9'h012: mask = 6'b000001;
            9'h059: mask = 6'b000010;
            9'h014: mask = 6'b000100;
            9'h114: mask = 6'b001000;
            9'h011: mask = 6'b010000;
            9'h111: mask = 6'b100000;
            default: mask = 6'b0;
        endcase
        ch = 8'h00;
        sh = 8'h00;
        case (bus.scancode)
            8'h1C: ch = "a"; 8'h32: ch = "b"; 8'h21: ch = "c"; 8'h23: ch = "d";
            8'h24: ch = "e"; 8'h2B: ch = "f"; 8'h34: ch = "g"; 8'h33: ch = "h";
            8'h43: ch = "i"; 8'h3B: ch = "j"; 8'h42: ch = "k"; 8'h4B: ch = "l";
            8'h3A: ch = "m"; 8'h31: ch = "n"; 8'h44: ch = "o"; 8'h4D: ch = "p";
            8'h15: ch = "q"; 8'h2D: ch = "r"; 8'h1B: ch = "s"; 8'h2C: ch = "t";
            8'h3C: ch = "u"; 8'h2A: ch = "v"; 8'h1D: ch = "w"; 8'h22: ch = "x";
            8'h35: ch = "y"; 8'h1A: ch = "z";
            8'h16: {ch, sh} = {"1", "!"}; 8'h1E: {ch, sh} = {"2", "@"};
            8'h26: {ch, sh} = {"3", "#"}; 8'h25: {ch, sh} = {"4", "$"};
            8'h2E: {ch, sh} = {"5", "%"}; 8'h36: {ch, sh} = {"6", "^"};
            8'h3D: {ch, sh} = {"7", "&"}; 8'h3E: {ch, sh} = {"8", "*"};
            8'h46: {ch, sh} = {"9", "("}; 8'h45: {ch, sh} = {"0", ")"};
            8'h0E: {ch, sh} = {8'h60, 8'h7E}; 8'h4E: {ch, sh} = {"-", "_"};
            8'h55: {ch, sh} = {"=", "+"}; 8'h54: {ch, sh} = {"[", "{"};
            8'h5B: {ch, sh} = {"]", "}"}; 8'h5D: {ch, sh} = {8'h5C, 8'h7C};
            8'h4C: {ch, sh} = {";", ":"}; 8'h52: {ch, sh} = {8'h27, 8'h22};
            8'h41: {ch, sh} = {",", "<"}; 8'h49: {ch, sh} = {".", ">"};
            8'h4A: {ch, sh} = {"/", "?"};
            8'h5A: {ch, sh} = {8'h0D, 8'h0D}; 8'h0D: {ch, sh} = {8'h09, 8'h09};
            8'h76: {ch, sh} = {8'h1B, 8'h1B}; 8'h66: {ch, sh} = {BS_CODE, BS_CODE};
            8'h29: {ch, sh} = {8'h20, 8'h20};
            default: {ch, sh} = 16'h0;
        endcase
        key = (ch inside {["a":"z"]}) ? (ctrl ? ((ch - 8'h20) & 8'h1F) : (shift ^ capsLock) ? ch - 8'h20 : ch)
              : shift ? sh : ch;
        base = {24'h0, key};
        blen = (ch != 8'h00) ? 3'd1 : 3'd0;
        if (ev_e0) begin
            case (bus.scancode)
                8'h75: {base, blen} = {32'h00415B1B, 3'd3};
                8'h72: {base, blen} = {32'h00425B1B, 3'd3};
                8'h74: {base, blen} = {32'h00435B1B, 3'd3};
                8'h6B: {base, blen} = {32'h00445B1B, 3'd3};
                8'h6C: {base, blen} = {32'h00485B1B, 3'd3};
                8'h69: {base, blen} = {32'h00465B1B, 3'd3};
                8'h71: {base, blen} = {32'h7E335B1B, 3'd4};
                default: {base, blen} = {32'h0, 3'd0};
            endcase
        end
        // first byte of a sequence sits in the low byte of seq
        prefix = ALT_ESC_PREFIX && alt && blen != 3'd0;
        seq = prefix ? {base, 8'h1B} : {8'h00, base};
        len = blen + 3'(prefix);
        free = (AW+1)'(QUEUE_DEPTH) - count;
        push = make_ev && len != 3'd0 && free >= (AW+1)'(len);
        drop = make_ev && len != 3'd0 && free < (AW+1)'(len);
        pop = count != '0 && !bus.fifoFull;
    end
    assign bus.fifoWriteRequest = pop;
    assign bus.fifoInData = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            skip <= '0;
            caps_held <= 1'b0;
            capsLock <= 1'b0;
            modifiers <= '0;
            droppedCount <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (bus.scancodeDone) begin
                case (state)
                    IDLE: begin
                        state <= bus.scancode == 8'hF0 ? BREAK : bus.scancode == 8'hE0 ? E0 :
                                 bus.scancode == 8'hE1 ? SKIP : IDLE;
                        skip <= 3'd7;
                    end
                    E0: state <= bus.scancode == 8'hF0 ? E0_BREAK : IDLE;
                    SKIP: begin
                        state <= skip == 3'd1 ? IDLE : SKIP;
                        skip <= skip - 3'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (make_ev) modifiers <= modifiers | mask;
            if (rel_ev) modifiers <= modifiers & ~mask;
            if (make_ev && !ev_e0 && bus.scancode == 8'h58) begin
                caps_held <= 1'b1;
                if (!caps_held) capsLock <= !capsLock;
            end
            if (rel_ev && !ev_e0 && bus.scancode == 8'h58) caps_held <= 1'b0;
            if (push) begin
                for (int i = 0; i < 5; i++)
                    if (i < int'(len)) mem[wr_ptr + AW'(i)] <= seq[8*i +: 8];
                wr_ptr <= wr_ptr + AW'(len);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (push ? (AW+1)'(len) : '0) - (AW+1)'(pop);
            if (drop && !(&droppedCount)) droppedCount <= droppedCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_sequence_translator.sv
// tb_ps2_sequence_translator: scoreboard bench; expected bytes are queued as
// keys are sent and popped by a monitor on every FIFO write.
module tb_ps2_sequence_translator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic caps_lock;
    logic [5:0] modifiers;
    logic [7:0] dropped_count;
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    ps2_sequence_translator_if bus();

    ps2_sequence_translator dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .capsLock(caps_lock),
        .modifiers(modifiers),
        .droppedCount(dropped_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.fifoWriteRequest) begin
            n_cmp++;
            if (bus.fifoFull) begin
                n_fail++;
                $display("FAIL write_while_full: wrote 0x%02h while fifoFull high", bus.fifoInData);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got 0x%02h, expected no write", bus.fifoInData);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.fifoInData !== e) begin
                    n_fail++;
                    $display("FAIL byte: got 0x%02h, expected 0x%02h", bus.fifoInData, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] code);
        @(posedge clk);
        #1 bus.scancodeDone = 1'b1;
        bus.scancode = code;
        @(posedge clk);
        #1 bus.scancodeDone = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic check_mods(input string name, input logic [5:0] e);
        n_cmp++;
        if (modifiers !== e) begin
            n_fail++;
            $display("FAIL %s: modifiers=%b expected %b", name, modifiers, e);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.fifoWriteRequest, caps_lock, modifiers, dropped_count} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: wr=%b caps=%b mods=%b drop=%0d expected all 0",
                     bus.fifoWriteRequest, caps_lock, modifiers, dropped_count);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(8'h61);
        send(8'h1C);
        @(negedge clk);
        n_cmp++;
        if (bus.fifoWriteRequest !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: fifoWriteRequest=%b in cycle N+1, expected 1", bus.fifoWriteRequest);
        end
        send(8'hF0); send(8'h1C);
        send(8'h12);
        check_mods("lshift_held", 6'b000001);
        exp_q.push_back(8'h41);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        check_mods("shift_released", 6'b000000);
        send(8'hAA);
        exp_q.push_back(8'h0D);
        send(8'h5A);
        send(8'h59);
        exp_q.push_back(8'h21);
        send(8'h16);
        send(8'hF0); send(8'h59);
        wait_drain("basic");
    endtask

    task automatic test_ctrl_caps();
        send(8'h14);
        check_mods("lctrl_held", 6'b000100);
        exp_q.push_back(8'h03);
        send(8'h21); send(8'hF0); send(8'h21); send(8'hF0); send(8'h14);
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        n_cmp++;
        if (caps_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL caps_on: capsLock=%b expected 1", caps_lock);
        end
        exp_q.push_back(8'h41);
        send(8'h1C);
        exp_q.push_back(8'h31);
        send(8'h16);
        send(8'h58); send(8'hF0); send(8'h58);
        n_cmp++;
        if (caps_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL caps_off: capsLock=%b expected 0", caps_lock);
        end
        wait_drain("ctrl_caps");
    endtask

    task automatic test_backpressure();
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h41);
        send(8'hE0); send(8'h75);
        @(posedge clk);
        #1 bus.fifoFull = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.fifoWriteRequest !== 1'b0) begin
                n_fail++;
                $display("FAIL stall: fifoWriteRequest=%b while full, expected 0", bus.fifoWriteRequest);
            end
        end
        @(posedge clk);
        #1 bus.fifoFull = 1'b0;
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h44);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h6B);
        wait_drain("backpressure");
    endtask

    task automatic test_alt();
        send(8'h11);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h61);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h11);
        send(8'hE0); send(8'h11);
        check_mods("ralt_held", 6'b100000);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
        exp_q.push_back(8'h33); exp_q.push_back(8'h7E);
        send(8'hE0); send(8'h71);
        send(8'hE0); send(8'hF0); send(8'h11);
        check_mods("ralt_released", 6'b000000);
        wait_drain("alt");
    endtask

    task automatic test_pause();
        logic [7:0] p [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (p[i]) send(p[i]);
        check_mods("pause_no_ctrl", 6'b000000);
        exp_q.push_back(8'h61);
        send(8'h1C);
        wait_drain("pause");
    endtask

    task automatic test_overflow();
        logic [7:0] c [14] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31};
        bus.fifoFull = 1'b1;
        foreach (c[i]) begin
            exp_q.push_back(8'h61 + 8'(i));
            send(c[i]);
        end
        send(8'hE0); send(8'h71);
        n_cmp++;
        if (dropped_count !== 8'd1) begin
            n_fail++;
            $display("FAIL dropped: droppedCount=%0d expected 1", dropped_count);
        end
        exp_q.push_back(8'h61);
        send(8'h1C);
        @(posedge clk);
        #1 bus.fifoFull = 1'b0;
        wait_drain("overflow");
    endtask

    task automatic test_reset_drain();
        bus.fifoFull = 1'b1;
        repeat (5) begin
            exp_q.push_back(8'h7A);
            send(8'h1A);
        end
        @(posedge clk);
        #1 bus.fifoFull = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (bus.fifoWriteRequest !== 1'b0 || dropped_count !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_drain: wr=%b drop=%0d expected 0/0", bus.fifoWriteRequest, dropped_count);
            end
        end
    endtask

    initial begin
        bus.scancodeDone = 1'b0;
        bus.scancode = 8'h00;
        bus.fifoFull = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ctrl_caps();
        test_backpressure();
        test_alt();
        test_pause();
        test_overflow();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
